pipelined_prefix_addsub: RTL and testbench

- Parametrised, pipelined Kogge-Stone parallel-prefix adder/subtractor using the team's kill/propagate/generate (KPG) carry encoding.
- Generalises the fixed 16-bit combinational prefix adder in three ways: WIDTH is a parameter, there is one register per prefix level, and it adds a subtract mode, status flags and a valid/ready handshake.
- Sits between operand alignment and normalisation in the floating-point adder datapath.

---
 rtl/pipelined_prefix_addsub_pkg.sv | 17 +
 rtl/pipelined_prefix_addsub_prefix_level.sv | 24 ++
 rtl/pipelined_prefix_addsub.sv | 113 +++++++++++
 tb/tb_pipelined_prefix_addsub.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_prefix_addsub_pkg.sv
// addsub_pkg: shared types and helpers for the pipelined prefix adder/subtractor.
//   kpg_t       - 2-bit kill/propagate/generate carry encoding
//   KPG_K/P/G   - encodings for kill (00), propagate (01), generate (11)
//   kpg_combine - prefix operator (hi o lo): hi unless hi propagates, then lo
package addsub_pkg;

   typedef logic [1:0] kpg_t;

   localparam kpg_t KPG_K = 2'b00;
   localparam kpg_t KPG_P = 2'b01;
   localparam kpg_t KPG_G = 2'b11;

   function automatic kpg_t kpg_combine(input kpg_t hi, input kpg_t lo);
      return (hi != KPG_P) ? hi : lo;
   endfunction

endpackage

// File: rtl/pipelined_prefix_addsub_prefix_level.sv
// prefix_level: one combinational Kogge-Stone level over WIDTH+1 KPG positions.
//   WIDTH - operand width (positions 0..WIDTH, position 0 is the carry-in)
//   DIST  - combine distance for this level
//   kin   - KPG vector from the previous stage register
//   kout  - KPG vector after combining position i with position i-DIST
module prefix_level
   import addsub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIST  = 1
) (
   input  kpg_t [WIDTH:0] kin,
   output kpg_t [WIDTH:0] kout
);

   for (genvar i = 0; i <= WIDTH; i++) begin : g_pos
      if (i >= DIST) begin : g_comb
         assign kout[i] = kpg_combine(kin[i], kin[i-DIST]);
      end else begin : g_pass
         assign kout[i] = kin[i];
      end
   end

endmodule

// File: rtl/pipelined_prefix_addsub.sv
// pipelined_prefix_addsub: pipelined Kogge-Stone adder/subtractor, KPG carry encoding.
//   clk, rst             - clock, synchronous active-high reset
//   in_valid/in_ready    - operand handshake (in_ready = ~out_valid | out_ready)
//   a, b, cin, sub       - operands; sub=1 computes a-b and ignores cin
//   out_valid/out_ready  - result handshake; results held while stalled
//   sum, cout, ovf, zero - result mod 2^WIDTH, carry out, signed overflow, sum==0
// Latency LEVELS+2 cycles: input register, one register per prefix level, output register.
module pipelined_prefix_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int LEVELS = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int STAGES = LEVELS + 2;

   logic              en;
   logic [STAGES-1:0] vld_pipe;

   // Whole pipe moves as one; a stalled output freezes every stage.
   assign en        = ~out_valid | out_ready;
   assign in_ready  = en;
   assign out_valid = vld_pipe[STAGES-1];

   // Stage 0 inputs: position 0 holds the carry-in, position i+1 holds bit i.
   logic [WIDTH-1:0] b_eff;
   logic             c0;
   kpg_t [WIDTH:0]   kpg_in;

   always_comb begin
      b_eff     = sub ? ~b : b;
      c0        = sub ? 1'b1 : cin;
      kpg_in    = '0;
      kpg_in[0] = c0 ? KPG_G : KPG_K;
      for (int i = 0; i < WIDTH; i++) begin
         kpg_in[i+1] = {a[i] & b_eff[i], a[i] | b_eff[i]};
      end
   end

   kpg_t [WIDTH:0]   kpg_q  [0:LEVELS];
   kpg_t [WIDTH:0]   kpg_d  [1:LEVELS];
   logic [WIDTH-1:0] pxor_q [0:LEVELS];

   for (genvar j = 1; j <= LEVELS; j++) begin : g_lvl
      prefix_level #(
         .WIDTH (WIDTH),
         .DIST  (1 << (j-1))
      ) u_lvl (
         .kin  (kpg_q[j-1]),
         .kout (kpg_d[j])
      );
   end

   // After LEVELS levels the top position spans back only to position 1, so a
   // surviving propagate there (all bits propagating) is resolved against the
   // carry-in at position 0. Every other position already reaches position 0.
   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_d;

   always_comb begin
      carry = '0;
      for (int i = 0; i <= WIDTH; i++) begin
         carry[i] = (kpg_q[LEVELS][i] == KPG_P) ? (kpg_q[LEVELS][0] == KPG_G)
                                                : (kpg_q[LEVELS][i] == KPG_G);
      end
      sum_d = pxor_q[LEVELS] ^ carry[WIDTH-1:0];
   end

   // Valid bits and visible outputs: cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
         sum      <= '0;
         cout     <= 1'b0;
         ovf      <= 1'b0;
         zero     <= 1'b0;
      end else if (en) begin
         vld_pipe <= {vld_pipe[STAGES-2:0], in_valid};
         sum      <= sum_d;
         cout     <= carry[WIDTH];
         ovf      <= carry[WIDTH] ^ carry[WIDTH-1];
         zero     <= ~|sum_d;
      end
   end

   // Internal datapath registers: no reset needed, qualified by vld_pipe.
   always_ff @(posedge clk) begin
      if (en) begin
         kpg_q[0]  <= kpg_in;
         pxor_q[0] <= a ^ b_eff;
         for (int j = 1; j <= LEVELS; j++) begin
            kpg_q[j]  <= kpg_d[j];
            pxor_q[j] <= pxor_q[j-1];
         end
      end
   end

endmodule

// File: tb/tb_pipelined_prefix_addsub.sv
module tb_pipelined_prefix_addsub;

   localparam int W   = 16;
   localparam int LAT = $clog2(W) + 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         cin = 1'b0;
   logic         sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] sum;
   logic         cout, ovf, zero;

   pipelined_prefix_addsub #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] s;
      logic         c;
      logic         o;
      logic         z;
   } res_t;

   res_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;
   bit   rnd_done;

   // Reference: plain integer arithmetic on the operands.
   function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic ci, input logic sb);
      res_t   r;
      longint u;
      int     sx, sy, s;
      sx = int'($signed(x));
      sy = int'($signed(y));
      if (sb) begin
         u   = longint'(x) - longint'(y);
         r.c = (x >= y);
         s   = sx - sy;
      end else begin
         u   = longint'(x) + longint'(y) + longint'(ci);
         r.c = u[W];
         s   = sx + sy + int'(ci);
      end
      r.s = u[W-1:0];
      r.o = (s > 32767) || (s < -32768);
      r.z = (r.s == '0);
      return r;
   endfunction

   task automatic check(input string name, input longint act, input longint expv);
      checks++;
      if (act != expv) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci, input logic sb);
      int tries = 0;
      a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
      #1;
      while (!in_ready && tries < 200) begin
         @(negedge clk); #1;
         tries++;
      end
      if (!in_ready) begin
         check("send_timeout", 0, 1);
      end else begin
         exp_q.push_back(model(x, y, ci, sb));
      end
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Pipe must be empty; counts edges from the accept edge until out_valid.
   task automatic measure_latency(input string name);
      int cnt = 1;
      while (!out_valid && cnt < 40) begin
         @(posedge clk); #1;
         cnt++;
      end
      check(name, cnt, LAT);
      @(negedge clk);
   endtask

   task automatic drain();
      int n = 0;
      out_ready = 1'b1;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("drain_empty", exp_q.size(), 0);
   endtask

   // Monitor: a result retires at the next edge when out_valid & out_ready.
   initial begin : monitor
      res_t got, prev;
      bit   held = 1'b0;
      forever begin
         @(negedge clk); #2;
         got = '{s: sum, c: cout, o: ovf, z: zero};
         if (!rst && out_valid) begin
            if (held) check("stall_stable", got, prev);
            if (out_ready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_out", 1, 0);
               end else begin
                  check("result", got, exp_q.pop_front());
               end
               held = 1'b0;
            end else begin
               held = 1'b1;
               prev = got;
            end
         end else begin
            held = 1'b0;
         end
      end
   end

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_sum", sum, 0);
      check("rst_flags", {cout, ovf, zero}, 0);
      @(negedge clk);

      // Directed cases
      send(16'h0056, 16'h005D, 1'b0, 1'b0);
      measure_latency("latency_first");
      send(16'hFFFF, 16'h0000, 1'b1, 1'b0);
      send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      send(16'h8000, 16'h0001, 1'b0, 1'b1);
      send(16'h0005, 16'h0007, 1'b1, 1'b1);
      send(16'h0000, 16'h0000, 1'b0, 1'b1);
      send(16'h8000, 16'h8000, 1'b0, 1'b0);
      send(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
      drain();

      // Back-to-back stream with a 4-cycle downstream stall
      fork
         begin
            for (int i = 0; i < 10; i++)
               send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
         end
         begin
            repeat (8) @(negedge clk);
            out_ready = 1'b0;
            #1;
            check("stall_out_valid", out_valid, 1);
            check("stall_in_ready", in_ready, 0);
            repeat (4) @(negedge clk);
            out_ready = 1'b1;
         end
      join
      drain();

      // Random traffic with bubbles and random backpressure
      rnd_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 80; i++) begin
               send(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
               repeat ($urandom_range(0, 1)) @(negedge clk);
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               out_ready = 1'($urandom_range(0, 3) != 0);
               @(negedge clk);
            end
         end
      join
      drain();

      // Reset mid-flight discards in-flight beats
      for (int i = 0; i < 3; i++)
         send(W'($urandom), W'($urandom), 1'b0, 1'b0);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_in_ready", in_ready, 1);
      check("midrst_sum", sum, 0);
      for (int i = 0; i < LAT; i++) begin
         check("midrst_no_out", out_valid, 0);
         @(negedge clk); #1;
      end
      @(negedge clk);
      send(16'h1234, 16'h4321, 1'b1, 1'b0);
      measure_latency("latency_after_rst");
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
